// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: requester and memory bus bundle for the unified memory arbiter.
interface unified_mem_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_en;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        stall_if;
    logic        stall_mem;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata,
               stall_if, stall_mem
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  i_rdata, i_ready, d_rdata, d_ready, m_en, m_we, m_addr, m_wdata,
               stall_if, stall_mem
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one fixed-latency memory port between fetch and memory stage.
// Define ARB_FAIR_EN to let a waiting fetch win after MAX_D_STREAK consecutive data grants.
module unified_mem_arbiter #(
    parameter int MEM_LAT      = 2,
    parameter int MAX_D_STREAK = 4
) (
    input logic                    clock,
    input logic                    resetn,
    unified_mem_arbiter_if.slave   bus
);
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_q;
    logic        owner_q;
    logic [4:0]  lat_q;
    logic [3:0]  streak_q, streak_d;
    logic        fetch_wins, data_gnt_d;
    logic        m_en_q, m_we_q, i_ready_q, d_ready_q;
    logic [31:0] m_addr_q, m_wdata_q, i_rdata_q, d_rdata_q;

    // Data is older in the pipeline, so it wins unless fetch has waited out its streak.
    always_comb begin
        fetch_wins = FAIR && bus.i_req && (streak_q == 4'(MAX_D_STREAK));
        data_gnt_d = bus.d_req && !fetch_wins;
        streak_d   = (FAIR && data_gnt_d && bus.i_req) ? streak_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            lat_q     <= 5'd0;
            streak_q  <= 4'd0;
            m_en_q    <= 1'b0;
            m_we_q    <= 1'b0;
            m_addr_q  <= 32'd0;
            m_wdata_q <= 32'd0;
            i_rdata_q <= 32'd0;
            d_rdata_q <= 32'd0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
        end else begin
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.i_req || bus.d_req) begin
                    state_q   <= BUSY;
                    owner_q   <= data_gnt_d;
                    lat_q     <= 5'(MEM_LAT - 1);
                    streak_q  <= streak_d;
                    m_en_q    <= 1'b1;
                    m_we_q    <= data_gnt_d && bus.d_we;
                    m_addr_q  <= data_gnt_d ? bus.d_addr : bus.i_addr;
                    m_wdata_q <= data_gnt_d ? bus.d_wdata : 32'd0;
                end
                BUSY: if (lat_q == 5'd0) begin
                    state_q <= DONE;
                    m_en_q  <= 1'b0;
                    m_we_q  <= 1'b0;
                    if (owner_q) begin
                        d_ready_q <= 1'b1;
                        if (!m_we_q) d_rdata_q <= bus.m_rdata;
                    end else begin
                        i_ready_q <= 1'b1;
                        i_rdata_q <= bus.m_rdata;
                    end
                end else begin
                    lat_q <= lat_q - 5'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.m_en      = m_en_q;
    assign bus.m_we      = m_we_q;
    assign bus.m_addr    = m_addr_q;
    assign bus.m_wdata   = m_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ready   = i_ready_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.stall_if  = bus.i_req & ~i_ready_q;
    assign bus.stall_mem = bus.d_req & ~d_ready_q;
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates a single unified memory port between the instruction-fetch stage (read-only) and the memory stage (load/store) of the 5-stage pipeline. It runs a multi-cycle access FSM against a fixed-latency memory and returns per-requester ready pulses. It also drives the `stall_if` / `stall_mem` signals that freeze the pipeline registers while an access is pending.

## Interface
- `MEM_LAT`, default 2: memory access cycles; legal range 1..16.
- `MAX_D_STREAK`, default 4: consecutive data grants allowed while fetch waits; used only with `ARB_FAIR_EN`; legal range 1..15.
- `clock`  in  1  — single clock; all state updates on the rising edge.
- `resetn`  in  1  — asynchronous, active-low reset.
- `i_req`  in  1  — fetch request; held until `i_ready`.
- `i_addr`  in  32  — fetch address.
- `i_rdata`  out  32  — fetched instruction; valid while `i_ready`=1, held afterwards.
- `i_ready`  out  1  — one-cycle completion pulse.
- `d_req`  in  1  — data request; held until `d_ready`.
- `d_we`  in  1  — 1 = store, 0 = load.
- `d_addr`  in  32  — data address.
- `d_wdata`  in  32  — store data.
- `d_rdata`  out  32  — load data; held afterwards; unchanged by stores.
- `d_ready`  out  1  — one-cycle completion pulse.
- `m_en`  out  1  — memory access enable.
- `m_we`  out  1  — memory write enable.
- `m_addr`  out  32  — memory address.
- `m_wdata`  out  32  — memory write data.
- `m_rdata`  in  32  — memory read data; valid in the last BUSY cycle.
- `stall_if`  out  1  — `i_req & ~i_ready` (combinational).
- `stall_mem`  out  1  — `d_req & ~d_ready` (combinational).

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: `owner` (I/D), `lat_cnt` (5 bits), `streak` (4 bits).
- **IDLE** with any request: grant, latch `m_addr`/`m_we`/`m_wdata` from the winner, set `lat_cnt`=MEM_LAT-1, go to BUSY.
  - Fetch grant forces `m_we`=0 and `m_wdata`=0.
  - IDLE with no request: stay in IDLE; `m_en`=0.
- **Priority:** data wins over fetch, because the memory-stage instruction is older.
- **BUSY:** `m_en`=1 and the address/control registers stay stable.
  - Decrement `lat_cnt` each cycle.
  - When `lat_cnt`=0: capture `m_rdata` into the owner's rdata register (loads and fetches only), go to DONE.
- **DONE:** pulse the owner's ready for this cycle only; `m_en`=0; next state is IDLE, unconditionally.
- **Request dropped mid-access:** the access still completes and the ready pulse is still issued. A store is therefore never torn.
- Request inputs are sampled only in IDLE; changes during BUSY/DONE are ignored.
- `m_en`/`m_we`/`m_addr`/`m_wdata` are registered outputs; `m_we` is cleared on entry to DONE.

## Timing
- **Reset:** all outputs 0 (including `i_rdata`/`d_rdata`), state IDLE, `lat_cnt`=0, `streak`=0.
- **Reset mid-access:** the access is aborted; `m_en`/`m_we` drop asynchronously; no ready pulse is issued after release.
- **Latency:** request seen in IDLE at cycle N → BUSY for cycles N+1..N+MEM_LAT → ready pulse at cycle N+MEM_LAT+1.
- **Throughput:** one access per MEM_LAT+2 cycles.
- **MEM_LAT=1:** BUSY lasts exactly one cycle.
- **Both requests present in IDLE:** data access first. Fetch is granted in the next IDLE if data is no longer requesting.

## Configuration
- **`ARB_FAIR_EN` defined:**
  - `streak` increments on each data grant made while `i_req`=1.
  - `streak` clears on any fetch grant, or on a data grant with `i_req`=0.
  - When `streak`=MAX_D_STREAK and both requests are present, fetch wins.
- **`ARB_FAIR_EN` undefined:** strict data priority; `streak` is held at 0.

## Test plan
- **Lone fetch** (MEM_LAT=2, `i_addr`=0x40, memory returns 0x8C020004): `i_ready` pulses exactly 3 cycles after the request; `i_rdata`=0x8C020004; `m_we`=0 throughout.
- **Store** (`d_addr`=0x100, `d_wdata`=0xDEADBEEF): `m_en`=`m_we`=1 for 2 cycles with stable address/data; `d_ready` pulses; `d_rdata` unchanged.
- **Simultaneous fetch and load:** data granted first; `d_ready` at N+3; fetch granted at N+4; `i_ready` at N+7; `stall_if` high N..N+6.
- **Fairness** (`ARB_FAIR_EN`, MAX_D_STREAK=2, both requests held continuously): grant order D, D, I, D, D, I.
  - Without the macro: D only.
- **Reset mid-access:** `resetn` low in the second BUSY cycle → `m_en`=0 immediately; no `d_ready` after release; all outputs 0.
- **MEM_LAT=1 boundary:** back-to-back fetches give `i_ready` every 3 cycles with correct data.
